l2_req_queue: RTL

L2_REQ_QUEUE -- requirements
Module: l2_req_queue

---
 rtl/l2_req_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/l2_req_queue.sv
// Request queue between the data cache and the L2: a circular FIFO of line
// requests that coalesces repeats of the tail entry and counts requests lost when full.
module l2_req_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     in_wr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_wr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              merged,
  output logic [31:0]              dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Entry layout: {wr, line address}; storage is intentionally not reset.
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      merged_q, merged_d;
  logic [31:0]      dropped_q, dropped_d;

  logic [ENT_W-1:0] req_s;
  logic [ENT_W-1:0] tail_s;
  logic             in_ready_s;
  logic             pop_s;
  logic             merge_s;
  logic             push_s;
  logic             drop_s;

  // Handshake decode: readiness comes from the registered count only.
  always_comb begin
    req_s      = {in_wr, in_addr};
    tail_s     = mem_q[wr_ptr_q - PTR_ONE];
    in_ready_s = (count_q != CNT_FULL);
    pop_s      = (count_q != CNT_ZERO) && out_ready;
    // A tail that leaves this cycle cannot absorb the request.
    merge_s    = in_valid && (count_q != CNT_ZERO) && (tail_s == req_s) &&
                 !(pop_s && (count_q == CNT_ONE));
    push_s     = in_valid && in_ready_s && !merge_s;
    drop_s     = in_valid && !in_ready_s && !merge_s;
  end

  // Next-state for pointers, occupancy and statistics; flush wins over traffic.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    merged_d  = merged_q;
    dropped_d = dropped_q;
    if (flush) begin
      wr_ptr_d  = PTR_ZERO;
      rd_ptr_d  = PTR_ZERO;
      count_d   = CNT_ZERO;
      merged_d  = 32'd0;
      dropped_d = 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (merge_s) begin
        merged_d = merged_q + 32'd1;
      end else begin
        merged_d = merged_q;
      end
      if (drop_s) begin
        dropped_d = dropped_q + 32'd1;
      end else begin
        dropped_d = dropped_q;
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= CNT_ZERO;
      merged_q  <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      merged_q  <= merged_d;
      dropped_q <= dropped_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wr_ptr_q] <= req_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (count_q != CNT_ZERO);
  assign out_addr  = mem_q[rd_ptr_q][ADDR_W-1:0];
  assign out_wr    = mem_q[rd_ptr_q][ADDR_W];
  assign count     = count_q;
  assign merged    = merged_q;
  assign dropped   = dropped_q;

endmodule
